// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter with optional grant lock, sharing one single-port data memory among cores
module dm_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_LOCK  = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        lock,
  input  logic [NUM_CORES-1:0]        we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);
  localparam int IW = $clog2(NUM_CORES);
  localparam logic [NUM_CORES-1:0] ONE = {{(NUM_CORES-1){1'b0}}, 1'b1};
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, ptr_nx, owner, owner_nx, win, gidx;
  logic [7:0] lcnt, lcnt_nx;
  logic found, gv;
  int sel;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [RD_LAT-1:0] pv;
  logic [IW-1:0] pidx [RD_LAT];
  always_comb begin
    win = '0;
    found = 1'b0;
    sel = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      sel = (int'(ptr) + k) % NUM_CORES;
      if (!found && req[sel]) begin
        found = 1'b1;
        win = IW'(sel);
      end
    end
  end
  // a locked owner that pauses its requests keeps the memory unless it also drops lock
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    owner_nx = owner;
    lcnt_nx = lcnt;
    gv = state == LOCKED ? req[owner] : found;
    gidx = state == LOCKED ? owner : win;
    if (state == IDLE) begin
      if (found) begin
        ptr_nx = win == IW'(NUM_CORES - 1) ? '0 : win + 1'b1;
        if (lock[win]) begin
          state_nx = LOCKED;
          owner_nx = win;
          lcnt_nx = 8'd1;
        end
      end
    end else if (req[owner]) begin
      lcnt_nx = lcnt + 8'd1;
      if (!lock[owner] || ({1'b0, lcnt} + 9'd1 >= 9'(MAX_LOCK))) state_nx = IDLE;
    end else if (!lock[owner]) begin
      state_nx = IDLE;
    end
  end
  assign gnt = (gv && reset_n) ? ONE << gidx : '0;
  assign mem_we = |gnt & we[gidx];
  assign mem_addr = |gnt ? addr[gidx*ADDR_W +: ADDR_W] : addr_q;
  assign mem_wdata = |gnt ? wdata[gidx*DATA_W +: DATA_W] : wdata_q;
  assign rdata = mem_rdata;
  assign rvalid = pv[RD_LAT-1] ? ONE << pidx[RD_LAT-1] : '0;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      lcnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      owner <= owner_nx;
      lcnt <= lcnt_nx;
      addr_q <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) pidx[i] <= '0;
    end else begin
      pv[0] <= |gnt & ~we[gidx];
      pidx[0] <= gidx;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed scoreboard bench for dm_arbiter with a behavioural data memory
module tb_dm_arbiter;
  localparam int N = 4, AW = 8, DW = 16, RL = 2, ML = 4;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [N-1:0] req = '0, lock = '0, we = '0, gnt, rvalid;
  logic [AW-1:0] addr_a [N], addr_n [N];
  logic [DW-1:0] wdata_a [N], wdata_n [N];
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem [256];
  logic [AW-1:0] rpipe [RL];
  typedef struct packed {logic [N-1:0] g; logic w; logic [AW-1:0] a; logic [DW-1:0] d;} gexp_t;
  typedef struct packed {logic [N-1:0] v; logic [DW-1:0] d;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t ge;
  rexp_t re;
  int n_chk = 0, n_fail = 0;
  logic [AW-1:0] last_a = '0;
  logic [DW-1:0] last_d = '0;

  dm_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_LOCK(ML)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign addr[g*AW +: AW] = addr_a[g];
    assign wdata[g*DW +: DW] = wdata_a[g];
  end

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    rpipe[0] <= mem_addr;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = mem[rpipe[RL-1]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] w, input logic [N-1:0] eg);
    gexp_t e;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    req = r;
    lock = l;
    we = w;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = addr_n[i];
      wdata_a[i] = wdata_n[i];
    end
    e.g = eg;
    e.w = 1'b0;
    for (int i = 0; i < N; i++)
      if (eg[i]) begin
        e.w = w[i];
        last_a = addr_n[i];
        last_d = wdata_n[i];
      end
    e.a = last_a;
    e.d = last_d;
    gq.push_back(e);
  endtask

  task automatic rd_exp(input logic [N-1:0] v, input logic [DW-1:0] d);
    rq.push_back({v, d});
  endtask

  always @(negedge clock) begin
    if (gq.size() > 0) begin
      ge = gq.pop_front();
      check("gnt", 32'(gnt), 32'(ge.g));
      check("mem_we", 32'(mem_we), 32'(ge.w));
      check("mem_addr", 32'(mem_addr), 32'(ge.a));
      check("mem_wdata", 32'(mem_wdata), 32'(ge.d));
    end
    if (rvalid != '0) begin
      if (rq.size() == 0) check("rvalid_spurious", 32'(rvalid), 32'd0);
      else begin
        re = rq.pop_front();
        check("rvalid", 32'(rvalid), 32'(re.v));
        check("rdata", 32'(rdata), 32'(re.d));
      end
    end
  end

  initial begin
    addr_n = '{8'h10, 8'h11, 8'h1A, 8'h13};
    wdata_n = '{16'h1000, 16'h1001, 16'h1234, 16'h1003};
    addr_a = addr_n;
    wdata_a = wdata_n;
    req = 4'b1111;
    we = 4'b1111;
    @(negedge clock);
    @(negedge clock);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    // rotation after reset; core 2 also plants 0x1234 at 0x1A
    cyc(4'b1111, 4'b0000, 4'b1111, 4'b0001);
    cyc(4'b1111, 4'b0000, 4'b1111, 4'b0010);
    cyc(4'b1111, 4'b0000, 4'b1111, 4'b0100);
    cyc(4'b1111, 4'b0000, 4'b1111, 4'b1000);
    cyc(4'b1111, 4'b0000, 4'b1111, 4'b0001);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc(4'b0100, 4'b0000, 4'b0000, 4'b0100);
    rd_exp(4'b0100, 16'h1234);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // core 1 write ahead of core 3 with ptr=0, then read it back
    cyc(4'b1000, 4'b0000, 4'b1000, 4'b1000);
    addr_n[1] = 8'h05;
    wdata_n[1] = 16'hBEEF;
    cyc(4'b1010, 4'b0000, 4'b1010, 4'b0010);
    cyc(4'b1000, 4'b0000, 4'b1000, 4'b1000);
    addr_n[0] = 8'h05;
    cyc(4'b0001, 4'b0000, 4'b0000, 4'b0001);
    rd_exp(4'b0001, 16'hBEEF);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // core 0 locks for three accesses while core 2 waits
    cyc(4'b1000, 4'b0000, 4'b1000, 4'b1000);
    addr_n[0] = 8'h40;
    wdata_n[0] = 16'h4040;
    addr_n[2] = 8'h22;
    wdata_n[2] = 16'h2222;
    cyc(4'b0101, 4'b0001, 4'b0101, 4'b0001);
    cyc(4'b0101, 4'b0001, 4'b0101, 4'b0001);
    cyc(4'b0101, 4'b0000, 4'b0101, 4'b0001);
    cyc(4'b0100, 4'b0000, 4'b0100, 4'b0100);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // forced release after MAX_LOCK grants to core 1
    cyc(4'b0001, 4'b0000, 4'b0001, 4'b0001);
    addr_n[1] = 8'h50;
    wdata_n[1] = 16'h5151;
    addr_n[3] = 8'h53;
    wdata_n[3] = 16'h5353;
    repeat (ML) cyc(4'b1010, 4'b0010, 4'b1010, 4'b0010);
    cyc(4'b1010, 4'b0010, 4'b1010, 4'b1000);
    cyc(4'b0010, 4'b0010, 4'b1010, 4'b0010);
    cyc(4'b0000, 4'b0010, 4'b0000, 4'b0000);
    cyc(4'b1000, 4'b0010, 4'b1000, 4'b0000);
    cyc(4'b1000, 4'b0000, 4'b1000, 4'b0000);
    cyc(4'b1000, 4'b0000, 4'b1000, 4'b1000);
    // reset one cycle after a read grant drops the pending rvalid
    addr_n[2] = 8'h1A;
    cyc(4'b0100, 4'b0000, 4'b0000, 4'b0100);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    req = 4'b1111;
    we = 4'b1111;
    lock = 4'b0000;
    last_a = '0;
    last_d = '0;
    @(negedge clock);
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    cyc(4'b1111, 4'b0000, 4'b1111, 4'b0001);
    repeat (RL + 3) cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clock);
    #1;
    check("grant_queue_drained", 32'(gq.size()), 32'd0);
    check("read_queue_drained", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
